if_unit: RTL and testbench
==========================

# if_unit

Instruction fetch unit for the single-issue RISC-V core. Holds the architectural PC, fetches one instruction per transaction over a req/ack instruction-memory port, and presents it with its PC to the control decoder and datapath through a valid/ready handshake. On acceptance it consumes the decoder's `pc_sel` and the ALU's branch result to compute the next PC, closing the loop on the decode stage's outputs.

## Interface
- `RESET_PC`, 32'h0000_0000, PC fetched first after reset
- `clk`  in  1  core clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  fetch request, held until ack
- `imem_addr`  out  32  fetch address, stable while `imem_req`=1
- `imem_ack`  in  1  memory response valid; ignored outside FETCH
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`
- `inst`  out  32  registered instruction to decode
- `inst_pc`  out  32  PC of `inst`
- `inst_valid`  out  1  `inst`/`inst_pc` valid
- `inst_ready`  in  1  downstream accepts the instruction this cycle
- `pc_sel`  in  2  decoder next-PC select: 00 pc+4, 01 jal, 10 jalr, 11 branch; sampled on accept
- `branch_taken`  in  1  ALU compare result; sampled on accept, used only when `pc_sel`=11
- `imm`  in  32  sign-extended immediate; sampled on accept
- `rs1_val`  in  32  jalr base; sampled on accept
- `fault`  out  1  misaligned next-PC detected; sticky until reset
- `retired`  out  32  count of accepted instructions, wraps

## Operation
- States: FETCH, VALID, FAULT. Reset enters FETCH with PC=`RESET_PC`.
- FETCH: `imem_req`=1, `imem_addr`=PC. On a rising edge with `imem_ack`=1: `inst`←`imem_rdata`, `inst_pc`←PC, go to VALID.
- VALID: `inst_valid`=1, `imem_req`=0; `inst`/`inst_pc` held. On edge with `inst_ready`=1 (accept): `retired`+1, compute next PC from `inst_pc`:
  - 00 → `inst_pc`+4; 01 → `inst_pc`+`imm`; 10 → (`rs1_val`+`imm`) & ~32'h1; 11 → `branch_taken` ? `inst_pc`+`imm` : `inst_pc`+4.
  - next PC[1:0]≠00 → FAULT, PC unchanged; else PC←next PC, go to FETCH.
- FAULT: `imem_req`=0, `inst_valid`=0, `fault`=1; exit only by reset.
- All adds modulo 2^32; wrap from 32'hFFFF_FFFC +4 gives 0, not a fault.
- `retired` wraps 32'hFFFF_FFFF → 0.

## Timing
- Reset values: `imem_req`=1 once `rst_n` deasserts (0 while asserted), `imem_addr`=`RESET_PC`, `inst`=0, `inst_pc`=0, `inst_valid`=0, `fault`=0, `retired`=0, state FETCH.
- Ack may arrive in the first FETCH cycle; `inst_valid` rises the cycle after the ack edge. Minimum throughput: one instruction per 2 cycles (FETCH, VALID).
- `imem_addr` must not change while `imem_req`=1 and no ack; memory may stall indefinitely.
- `inst_ready` outside VALID is ignored; `pc_sel`/`branch_taken`/`imm`/`rs1_val` matter only on the accept edge.
- Reset mid-transaction: asynchronous clear to reset values immediately; an ack arriving in the cycle `rst_n` deasserts is accepted as the response for `RESET_PC`.
- All outputs are registered except `imem_addr` (= PC register) and `imem_req` (state decode).

## Structure
- Shared package `cpu_pkg`: `pc_sel` encodings (PC_PLUS4, PC_JAL, PC_JALR, PC_BRANCH), state enum, default `RESET_PC`; the decoder uses the same encodings.
- One combinational sub-module `next_pc_gen` (inputs `inst_pc`, `pc_sel`, `branch_taken`, `imm`, `rs1_val`; outputs next PC, misaligned flag); FSM, PC, instruction and counter registers in `if_unit`.

## Test plan
- Reset, ack on first cycle with `imem_rdata`=32'h0000_0013 → `imem_addr`=0, next cycle `inst_valid`=1, `inst`=32'h13, `inst_pc`=0.
- Accept with `pc_sel`=00 at PC 0x0, then 0x4 → next `imem_addr`=0x4 then 0x8, `retired`=2; memory stalls 5 cycles → `imem_addr` stable, `inst_valid`=0.
- Branch at PC 0x10, `imm`=-8: `branch_taken`=1 → next fetch 0x08; `branch_taken`=0 → 0x14; `pc_sel`=01, `imm`=0x100 → 0x110.
- jalr `rs1_val`=0x203, `imm`=0 → next fetch 0x202 → `fault`=1, `imem_req`=0, stays until reset; `rs1_val`=0x201 → 0x200, no fault.
- Hold `inst_ready`=0 for 4 cycles in VALID → `inst`/`inst_pc` stable, no new request, `retired` unchanged.
- Assert `rst_n`=0 mid-FETCH at PC 0x40 → all outputs reset immediately; after release first request at `RESET_PC`; `retired` preset near 32'hFFFF_FFFF wraps to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch unit and the control decoder.
package cpu_pkg;

    // Next-PC select, produced by the decoder and consumed by fetch.
    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_JAL    = 2'b01,
        PC_JALR   = 2'b10,
        PC_BRANCH = 2'b11
    } pc_sel_e;

    // Fetch unit control states.
    typedef enum logic [1:0] {
        StFetch = 2'b00,
        StValid = 2'b01,
        StFault = 2'b10
    } fetch_state_e;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/next_pc_gen.sv
// Combinational next-PC computation and misalignment detection.
module next_pc_gen
    import cpu_pkg::*;
(
    input  logic [31:0] i_inst_pc,
    input  pc_sel_e     i_pc_sel,
    input  logic        i_branch_taken,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_rs1_val,
    output logic [31:0] o_next_pc,
    output logic        o_misaligned
);

    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_imm;
    logic [31:0] w_jalr_tgt;

    assign w_pc_plus4 = i_inst_pc + 32'd4;
    assign w_pc_imm   = i_inst_pc + i_imm;
    // jalr clears bit 0 of the target; bit 1 can still be set and fault.
    assign w_jalr_tgt = (i_rs1_val + i_imm) & ~32'h1;

    // Select the next PC from the decoder's encoding.
    always_comb begin
        o_next_pc = w_pc_plus4;
        unique case (i_pc_sel)
            PC_PLUS4:  o_next_pc = w_pc_plus4;
            PC_JAL:    o_next_pc = w_pc_imm;
            PC_JALR:   o_next_pc = w_jalr_tgt;
            PC_BRANCH: o_next_pc = i_branch_taken ? w_pc_imm : w_pc_plus4;
            default:   o_next_pc = w_pc_plus4;
        endcase
    end

    assign o_misaligned = |o_next_pc[1:0];

endmodule

// File: rtl/if_unit.sv
// Instruction fetch unit: holds the PC, fetches over a req/ack port and
// hands each instruction to decode through a valid/ready handshake.
module if_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RETIRED_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    input  logic [1:0]  i_pc_sel,
    input  logic        i_branch_taken,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_rs1_val,
    output logic        o_fault,
    output logic [31:0] o_retired
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  r_inst;
    logic [31:0]  r_inst_pc;
    logic         r_inst_valid;
    logic         r_fault;
    logic [31:0]  r_retired;

    logic         w_fetch_done;
    logic         w_accept;
    logic [31:0]  w_next_pc;
    logic         w_misaligned;

    next_pc_gen u_next_pc_gen (
        .i_inst_pc      (r_inst_pc),
        .i_pc_sel       (pc_sel_e'(i_pc_sel)),
        .i_branch_taken (i_branch_taken),
        .i_imm          (i_imm),
        .i_rs1_val      (i_rs1_val),
        .o_next_pc      (w_next_pc),
        .o_misaligned   (w_misaligned)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and handshake strobes.
    always_comb begin
        w_state_next = r_state;
        w_fetch_done = 1'b0;
        w_accept     = 1'b0;
        unique case (r_state)
            StFetch: begin
                if (i_imem_ack) begin
                    w_fetch_done = 1'b1;
                    w_state_next = StValid;
                end
            end
            StValid: begin
                if (i_inst_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = w_misaligned ? StFault : StFetch;
                end
            end
            StFault: w_state_next = StFault;
            default: w_state_next = StFetch;
        endcase
    end

    // PC, instruction, status and retire-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_inst       <= 32'h0;
            r_inst_pc    <= 32'h0;
            r_inst_valid <= 1'b0;
            r_fault      <= 1'b0;
            r_retired    <= RETIRED_INIT;
        end else begin
            if (w_fetch_done) begin
                r_inst       <= i_imem_rdata;
                r_inst_pc    <= r_pc;
                r_inst_valid <= 1'b1;
            end
            if (w_accept) begin
                r_retired    <= r_retired + 32'd1;
                r_inst_valid <= 1'b0;
                // A misaligned target leaves the PC on the faulting instruction.
                if (w_misaligned) begin
                    r_fault <= 1'b1;
                end else begin
                    r_pc <= w_next_pc;
                end
            end
        end
    end

    // Request is gated by reset so it reads low while reset is held.
    assign o_imem_req   = rst_n && (r_state == StFetch);
    assign o_imem_addr  = r_pc;
    assign o_inst       = r_inst;
    assign o_inst_pc    = r_inst_pc;
    assign o_inst_valid = r_inst_valid;
    assign o_fault      = r_fault;
    assign o_retired    = r_retired;

endmodule

// File: tb/tb_if_unit.sv
// Self-checking bench for if_unit: table of next-PC vectors plus hand
// sequences for stalls, back-pressure, faults and mid-fetch reset.
module tb_if_unit;

    logic        clk;
    logic        rst_n;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;
    logic        i_inst_ready;
    logic [1:0]  i_pc_sel;
    logic        i_branch_taken;
    logic [31:0] i_imm;
    logic [31:0] i_rs1_val;

    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        o_inst_valid;
    logic        o_fault;
    logic [31:0] o_retired;

    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic [31:0] w_inst;
    logic [31:0] w_inst_pc;
    logic        w_inst_valid;
    logic        w_fault;
    logic [31:0] w_retired;

    if_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .o_imem_req     (o_imem_req),
        .o_imem_addr    (o_imem_addr),
        .i_imem_ack     (i_imem_ack),
        .i_imem_rdata   (i_imem_rdata),
        .o_inst         (o_inst),
        .o_inst_pc      (o_inst_pc),
        .o_inst_valid   (o_inst_valid),
        .i_inst_ready   (i_inst_ready),
        .i_pc_sel       (i_pc_sel),
        .i_branch_taken (i_branch_taken),
        .i_imm          (i_imm),
        .i_rs1_val      (i_rs1_val),
        .o_fault        (o_fault),
        .o_retired      (o_retired)
    );

    // Second copy with the retire counter preset just below wrap.
    if_unit #(
        .RETIRED_INIT (32'hFFFF_FFFE)
    ) dut_w (
        .clk            (clk),
        .rst_n          (rst_n),
        .o_imem_req     (w_imem_req),
        .o_imem_addr    (w_imem_addr),
        .i_imem_ack     (i_imem_ack),
        .i_imem_rdata   (i_imem_rdata),
        .o_inst         (w_inst),
        .o_inst_pc      (w_inst_pc),
        .o_inst_valid   (w_inst_valid),
        .i_inst_ready   (i_inst_ready),
        .i_pc_sel       (i_pc_sel),
        .i_branch_taken (i_branch_taken),
        .i_imm          (i_imm),
        .i_rs1_val      (i_rs1_val),
        .o_fault        (w_fault),
        .o_retired      (w_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic        taken;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] pc;
        logic [31:0] next_pc;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    localparam int NumVec = 12;

    vec_t        vecs[NumVec];
    exp_t        sb[$];
    int          n_checks;
    int          n_errors;
    logic [31:0] exp_ret;
    logic [31:0] exp_ret_w;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic scramble();
        i_pc_sel       = 2'($urandom);
        i_branch_taken = 1'($urandom);
        i_imm          = $urandom;
        i_rs1_val      = $urandom;
        i_imem_rdata   = $urandom;
    endtask

    // Serve one fetch after a stall, then monitor for the valid output.
    task automatic do_fetch(input int stall, input logic [31:0] word, input logic [31:0] pc);
        int   k;
        exp_t e;
        chk("fetch_req", {31'b0, o_imem_req}, 32'd1);
        chk("fetch_addr", o_imem_addr, pc);
        for (int s = 0; s < stall; s++) begin
            tick();
            chk("stall_addr", o_imem_addr, pc);
            chk("stall_valid", {31'b0, o_inst_valid}, 32'd0);
        end
        i_imem_ack   = 1'b1;
        i_imem_rdata = word;
        sb.push_back('{inst: word, pc: pc});
        tick();
        i_imem_ack   = 1'b0;
        i_imem_rdata = $urandom;
        k = 0;
        while (!o_inst_valid && k < 8) begin
            tick();
            k++;
        end
        chk("valid_latency", 32'(k), 32'd0);
        if (o_inst_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_empty: got valid expected no output");
            end else begin
                e = sb.pop_front();
                chk("inst", o_inst, e.inst);
                chk("inst_pc", o_inst_pc, e.pc);
                chk("valid_req", {31'b0, o_imem_req}, 32'd0);
            end
        end
    endtask

    task automatic do_accept(input logic [1:0] sel, input logic taken,
                             input logic [31:0] imm, input logic [31:0] rs1);
        i_pc_sel       = sel;
        i_branch_taken = taken;
        i_imm          = imm;
        i_rs1_val      = rs1;
        i_inst_ready   = 1'b1;
        tick();
        i_inst_ready = 1'b0;
        scramble();
        exp_ret   = exp_ret + 32'd1;
        exp_ret_w = exp_ret_w + 32'd1;
        chk("retired", o_retired, exp_ret);
        chk("retired_wrap", w_retired, exp_ret_w);
    endtask

    task automatic chk_reset_vals();
        chk("rst_req", {31'b0, o_imem_req}, 32'd0);
        chk("rst_addr", o_imem_addr, 32'h0);
        chk("rst_inst", o_inst, 32'h0);
        chk("rst_inst_pc", o_inst_pc, 32'h0);
        chk("rst_valid", {31'b0, o_inst_valid}, 32'd0);
        chk("rst_fault", {31'b0, o_fault}, 32'd0);
        chk("rst_retired", o_retired, 32'h0);
        chk("rst_retired_w", w_retired, 32'hFFFF_FFFE);
        exp_ret   = 32'h0;
        exp_ret_w = 32'hFFFF_FFFE;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst_n        = 1'b0;
        i_imem_ack   = 1'b0;
        i_inst_ready = 1'b0;
        i_pc_sel     = 2'b00;
        i_branch_taken = 1'b0;
        i_imm        = 32'h0;
        i_rs1_val    = 32'h0;
        i_imem_rdata = 32'h0;

        // sel, taken, imm, rs1, pc of instruction, next fetch address
        vecs[0]  = '{2'b00, 1'b0, 32'h0,         32'h0,         32'h0000_0000, 32'h0000_0004};
        vecs[1]  = '{2'b00, 1'b1, 32'h40,        32'h0,         32'h0000_0004, 32'h0000_0008};
        vecs[2]  = '{2'b01, 1'b0, 32'h8,         32'h0,         32'h0000_0008, 32'h0000_0010};
        vecs[3]  = '{2'b11, 1'b1, 32'hFFFF_FFF8, 32'h0,         32'h0000_0010, 32'h0000_0008};
        vecs[4]  = '{2'b01, 1'b0, 32'h8,         32'h0,         32'h0000_0008, 32'h0000_0010};
        vecs[5]  = '{2'b11, 1'b0, 32'hFFFF_FFF8, 32'h0,         32'h0000_0010, 32'h0000_0014};
        vecs[6]  = '{2'b01, 1'b1, 32'hFFFF_FFFC, 32'h0,         32'h0000_0014, 32'h0000_0010};
        vecs[7]  = '{2'b01, 1'b0, 32'h100,       32'h0,         32'h0000_0010, 32'h0000_0110};
        vecs[8]  = '{2'b10, 1'b0, 32'h0,         32'h201,       32'h0000_0110, 32'h0000_0200};
        vecs[9]  = '{2'b10, 1'b0, 32'hC,         32'hFFFF_FFF0, 32'h0000_0200, 32'hFFFF_FFFC};
        vecs[10] = '{2'b00, 1'b0, 32'h0,         32'h0,         32'hFFFF_FFFC, 32'h0000_0000};
        vecs[11] = '{2'b10, 1'b0, 32'h1,         32'h40,        32'h0000_0000, 32'h0000_0040};

        // Reset held: outputs at reset values, request low.
        tick();
        tick();
        chk_reset_vals();

        // Release; the first vector acks in the release cycle.
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < NumVec; i++) begin
            do_fetch(i % 3, 32'h13 | (32'(i) << 7), vecs[i].pc);
            do_accept(vecs[i].sel, vecs[i].taken, vecs[i].imm, vecs[i].rs1);
            chk("next_addr", o_imem_addr, vecs[i].next_pc);
            chk("next_req", {31'b0, o_imem_req}, 32'd1);
            chk("next_fault", {31'b0, o_fault}, 32'd0);
        end

        // Memory stalls at 0x40 with ready asserted; reset mid-fetch.
        i_inst_ready = 1'b1;
        for (int s = 0; s < 5; s++) begin
            tick();
            chk("mid_addr", o_imem_addr, 32'h40);
            chk("mid_valid", {31'b0, o_inst_valid}, 32'd0);
            chk("mid_retired", o_retired, exp_ret);
        end
        i_inst_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        tick();
        rst_n = 1'b1;
        #1;
        do_fetch(0, 32'h0000_0093, 32'h0);

        // Back-pressure: instruction held, no new request, no retire.
        for (int s = 0; s < 4; s++) begin
            tick();
            chk("hold_inst", o_inst, 32'h0000_0093);
            chk("hold_inst_pc", o_inst_pc, 32'h0);
            chk("hold_valid", {31'b0, o_inst_valid}, 32'd1);
            chk("hold_req", {31'b0, o_imem_req}, 32'd0);
            chk("hold_retired", o_retired, exp_ret);
        end

        // jalr to 0x202 is misaligned: fault sticks until reset.
        do_accept(2'b10, 1'b0, 32'h0, 32'h203);
        chk("fault_set", {31'b0, o_fault}, 32'd1);
        chk("fault_req", {31'b0, o_imem_req}, 32'd0);
        chk("fault_valid", {31'b0, o_inst_valid}, 32'd0);
        chk("fault_pc", o_imem_addr, 32'h0);
        i_imem_ack   = 1'b1;
        i_inst_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("fault_sticky", {31'b0, o_fault}, 32'd1);
            chk("fault_req_hold", {31'b0, o_imem_req}, 32'd0);
            chk("fault_retired", o_retired, exp_ret);
        end
        i_imem_ack   = 1'b0;
        i_inst_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        tick();
        rst_n = 1'b1;
        #1;
        do_fetch(1, 32'h0000_0113, 32'h0);
        do_accept(2'b00, 1'b0, 32'h0, 32'h0);
        chk("post_fault_addr", o_imem_addr, 32'h4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
